// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration bitstream loader: FSM state codes,
// words-per-column arithmetic and counter width helpers.
package cfg_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_SHIFT  = 3'd2;
  localparam state_t ST_CHECK  = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

  // Words per column, rounded up so a partial top word still gets a slot.
  function automatic int calc_wpc(input int height, input int word_w);
    return (height + word_w - 1) / word_w;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int word_cnt_w(input int height, input int word_w);
    return cnt_width(calc_wpc(height, word_w));
  endfunction

  function automatic int col_cnt_w(input int width);
    return cnt_width(width);
  endfunction

endpackage

// File: rtl/cfg_col_assembler.sv
// Packs incoming words into one configuration column and latches the finished
// column into the register that drives cdata.
module cfg_col_assembler
  import cfg_loader_pkg::*;
#(
  parameter int CFG_HEIGHT = 40,
  parameter int WORD_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [WORD_W-1:0]     in_data,
  output logic                  col_done,
  output logic [CFG_HEIGHT-1:0] col_data
);

  localparam int WPC    = calc_wpc(CFG_HEIGHT, WORD_W);
  localparam int WC_W   = word_cnt_w(CFG_HEIGHT, WORD_W);
  localparam int PACK_W = WPC * WORD_W;

  logic [PACK_W-1:0]     pack_q, pack_d;
  logic [WC_W-1:0]       word_cnt_q, word_cnt_d;
  logic [CFG_HEIGHT-1:0] col_q, col_d;
  logic                  last_word;

  assign last_word = (word_cnt_q == WC_W'(WPC - 1));
  assign col_done  = accept && last_word;
  assign col_data  = col_q;

  // The column register takes the packed words including the one arriving
  // now, so cdata only moves when a column completes.
  always_comb begin
    pack_d     = pack_q;
    word_cnt_d = word_cnt_q;
    col_d      = col_q;
    if (clear) begin
      word_cnt_d = '0;
    end else if (accept) begin
      for (int k = 0; k < WPC; k++) begin
        if (word_cnt_q == WC_W'(k)) begin
          pack_d[k*WORD_W +: WORD_W] = in_data;
        end
      end
      if (last_word) begin
        word_cnt_d = '0;
        col_d      = pack_d[CFG_HEIGHT-1:0];
      end else begin
        word_cnt_d = word_cnt_q + WC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack_q     <= '0;
      word_cnt_q <= '0;
      col_q      <= '0;
    end else begin
      pack_q     <= pack_d;
      word_cnt_q <= word_cnt_d;
      col_q      <= col_d;
    end
  end

endmodule

// File: rtl/cfg_bitstream_loader.sv
// Streams 32-bit words into the fabric configuration shift port, one shift per column.
// Optional CFG_CHECKSUM_EN adds a trailing checksum word compared against the data sum.
module cfg_bitstream_loader
  import cfg_loader_pkg::*;
#(
  parameter int CFG_HEIGHT = 40,
  parameter int CFG_WIDTH  = 16,
  parameter int WORD_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  in_valid,
  input  logic [WORD_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  shift,
  output logic [CFG_HEIGHT-1:0] cdata
);

  localparam int CC_W = col_cnt_w(CFG_WIDTH);

  state_t          state_q, state_d;
  logic [CC_W-1:0] col_cnt_q, col_cnt_d;
  logic            accept;
  logic            clear;
  logic            col_done;
  logic            last_col;

  assign clear    = start && (state_q == ST_IDLE);
  assign accept   = in_valid && (state_q == ST_LOAD);
  assign last_col = (col_cnt_q == CC_W'(CFG_WIDTH - 1));

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_FINISH);
  assign shift = (state_q == ST_SHIFT);

`ifdef CFG_CHECKSUM_EN
  assign in_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
  assign in_ready = (state_q == ST_LOAD);
`endif

  cfg_col_assembler #(
    .CFG_HEIGHT (CFG_HEIGHT),
    .WORD_W     (WORD_W)
  ) u_assembler (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .accept   (accept),
    .in_data  (in_data),
    .col_done (col_done),
    .col_data (cdata)
  );

  // start is only honoured from IDLE, so a repeat request mid-load is dropped.
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          col_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (col_done) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        col_cnt_d = col_cnt_q + CC_W'(1);
        if (last_col) begin
`ifdef CFG_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_FINISH;
`endif
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef CFG_CHECKSUM_EN
      ST_CHECK: begin
        if (in_valid) state_d = ST_FINISH;
      end
`endif
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      col_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
    end
  end

`ifdef CFG_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        err_q, err_d;

  // The checksum word itself is never folded into the running sum.
  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (clear) begin
      sum_d = '0;
      err_d = 1'b0;
    end else if (accept) begin
      sum_d = sum_q + 32'(in_data);
    end else if ((state_q == ST_CHECK) && in_valid) begin
      err_d = (32'(in_data) != sum_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Self-checking bench for cfg_bitstream_loader with a 4-column bitstream.
// Expected columns are queued as words are accepted and popped on every shift.
module tb_cfg_bitstream_loader;

  localparam int H  = 40;
  localparam int W  = 4;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [WW-1:0] in_data = '0;
  logic          busy, done, err, in_ready, shift;
  logic [H-1:0]  cdata;

  int            n_vectors = 0;
  int            n_fails = 0;
  int            cycle_cnt = 0;
  int            last_shift_cycle = 0;
  int            shift_count = 0;
  int            done_count = 0;
  bit            check_spacing = 1'b0;
  logic [31:0]   model_sum = '0;
  logic [H-1:0]  exp_q[$];

  always #5 clk = ~clk;

  cfg_bitstream_loader #(
    .CFG_HEIGHT (H),
    .CFG_WIDTH  (W),
    .WORD_W     (WW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .shift    (shift),
    .cdata    (cdata)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vectors++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cycle_cnt++;
  end

  // Consumer side of the scoreboard: every shift must match the oldest queued column.
  initial forever begin
    @(negedge clk);
    if (rst && done) done_count++;
    if (rst && shift) begin
      if (check_spacing && shift_count > 0)
        checkOutput("shift_spacing", 64'(cycle_cnt - last_shift_cycle), 64'd3);
      shift_count++;
      last_shift_cycle = cycle_cnt;
      if (exp_q.size() == 0) checkOutput("unexpected_shift", 64'd1, 64'd0);
      else                   checkOutput("cdata", 64'(cdata), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [31:0] w, input int gap, input bit push,
                               input logic [H-1:0] exp_col);
    int budget = 50;
    bit got = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (!got && budget > 0) begin
      if (in_ready) begin
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
        budget--;
      end
    end
    if (!got) checkOutput("accept_timeout", 64'd0, 64'd1);
    else if (push) exp_q.push_back(exp_col);
    if (gap > 0) begin
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic sendColumn(input logic [31:0] w0, input logic [31:0] w1, input int gap);
    logic [63:0] both;
    both = {w1, w0};
    model_sum = model_sum + w0 + w1;
    applyStimulus(w0, gap, 1'b0, '0);
    applyStimulus(w1, gap, 1'b1, both[H-1:0]);
  endtask

  task automatic startLoad();
    @(negedge clk);
    exp_q.delete();
    shift_count = 0;
    done_count  = 0;
    model_sum   = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    checkOutput("err_after_start", 64'(err), 64'd0);
  endtask

  task automatic finishLoad(input logic [31:0] ck_word, input bit exp_err);
    int budget = 20;
    bit seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
`ifdef CFG_CHECKSUM_EN
    applyStimulus(ck_word, 1, 1'b0, '0);
`endif
    while (!seen && budget > 0) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        budget--;
      end
    end
    checkOutput("done_seen", 64'(seen), 64'd1);
`ifndef CFG_CHECKSUM_EN
    checkOutput("done_latency", 64'(cycle_cnt - last_shift_cycle), 64'd1);
`endif
    checkOutput("err_at_done", 64'(err), 64'(exp_err));
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(done), 64'd0);
    checkOutput("busy_after_done", 64'(busy), 64'd0);
    checkOutput("done_count", 64'(done_count), 64'd1);
    checkOutput("shift_count", 64'(shift_count), 64'(W));
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_shift", 64'(shift), 64'd0);
    checkOutput("rst_cdata", 64'(cdata), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] idle ignores in_valid");
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    checkOutput("idle_in_ready", 64'(in_ready), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;

    $display("[TB] back-to-back load");
    check_spacing = 1'b1;
    startLoad();
    for (int c = 0; c < W; c++)
      sendColumn(32'(c + 1), 32'hAA + 32'h11 * 32'(c), 0);
    finishLoad(model_sum, 1'b0);
    check_spacing = 1'b0;

    $display("[TB] in_valid toggling every other cycle");
    startLoad();
    for (int c = 0; c < W; c++)
      sendColumn(32'(c + 1), 32'hAA + 32'h11 * 32'(c), 1);
    finishLoad(model_sum, 1'b0);

    $display("[TB] start pulsed during column 2");
    startLoad();
    sendColumn(32'h1111_0000, 32'h0000_0011, 0);
    model_sum = model_sum + 32'h2222_0000 + 32'h0000_0022;
    applyStimulus(32'h2222_0000, 0, 1'b0, '0);
    start = 1'b1;
    applyStimulus(32'h0000_0022, 0, 1'b1, 40'h22_2222_0000);
    start = 1'b0;
    checkOutput("busy_ignored_start", 64'(busy), 64'd1);
    sendColumn(32'h3333_0000, 32'h0000_0033, 0);
    sendColumn(32'h4444_0000, 32'h0000_0044, 0);
    finishLoad(model_sum, 1'b0);

    $display("[TB] reset after column 1");
    startLoad();
    sendColumn(32'hCAFE_0001, 32'h0000_005A, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("midrst_shift", 64'(shift), 64'd0);
    checkOutput("midrst_cdata", 64'(cdata), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("midrst_queue", 64'(exp_q.size()), 64'd0);
    startLoad();
    for (int c = 0; c < W; c++)
      sendColumn(32'h5000_0000 + 32'(c), 32'h0000_00E0 + 32'(c), 0);
    finishLoad(model_sum, 1'b0);

    $display("[TB] upper-bit truncation");
    startLoad();
    sendColumn(32'h0123_4567, 32'hFFFF_FFFF, 0);
    for (int c = 1; c < W; c++)
      sendColumn(32'h0000_0100 * 32'(c), 32'h0000_0010 * 32'(c), 0);
    finishLoad(model_sum, 1'b0);

`ifdef CFG_CHECKSUM_EN
    $display("[TB] checksum match");
    startLoad();
    sendColumn(32'h0000_1000, 32'h0000_0200, 0);
    sendColumn(32'h0000_0030, 32'h0000_0004, 0);
    sendColumn(32'h0, 32'h0, 0);
    sendColumn(32'h0, 32'h0, 0);
    finishLoad(32'h0000_1234, 1'b0);

    $display("[TB] checksum mismatch");
    startLoad();
    sendColumn(32'h0000_1000, 32'h0000_0200, 0);
    sendColumn(32'h0000_0030, 32'h0000_0004, 0);
    sendColumn(32'h0, 32'h0, 0);
    sendColumn(32'h0, 32'h0, 0);
    finishLoad(32'h0000_1235, 1'b1);
    checkOutput("err_sticky", 64'(err), 64'd1);
    startLoad();
    checkOutput("err_cleared_by_start", 64'(err), 64'd0);
    for (int c = 0; c < W; c++)
      sendColumn(32'(c), 32'(c), 0);
    finishLoad(model_sum, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fails);
    $finish;
  end

endmodule
